spi_master_tx: RTL and testbench

SPI master transmitter that drives the `spi_bus` interface through its `master` modport, generating `sclk`, `cs_n` and `mosi`. It takes parallel words over a valid/ready stream and shifts them out in SPI mode 0 (CPOL=0, CPHA=0) at a programmable SCLK rate. A `s_last` flag lets consecutive words share one chip-select frame. It sits between on-chip producers and the off-chip or peer SPI slave on the same bus.

---
 rtl/spi_master_tx_if.sv | 9 +
 rtl/spi_master_tx.sv | 144 ++++++++++++++
 tb/tb_spi_master_tx.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_tx_if.sv
// SPI bus bundle: the master drives sclk, cs_n and mosi; a slave observes them.
interface spi_bus;
  logic sclk;
  logic cs_n;
  logic mosi;

  modport master (output sclk, output cs_n, output mosi);
  modport slave  (input  sclk, input  cs_n, input  mosi);
endinterface

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter: valid/ready words in, shifted out on mosi.
// Words without s_last chain into the same chip-select frame.
module spi_master_tx #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 2,
  parameter int CS_GAP    = 2,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              busy,
  spi_bus.master            spi
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (DATA_W  > 1) ? $clog2(DATA_W)  : 1;
  localparam int GAP_W = (CS_GAP  > 1) ? $clog2(CS_GAP)  : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_MAX = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    HIGH,
    LOW,
    TRAIL,
    WAIT,
    GAP
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  shifted;
  logic               last_q;
  logic               div_done;
  logic               xfer;

  function automatic logic first_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  assign div_done = (div_cnt == DIV_MAX);
  assign shifted  = (LSB_FIRST != 0) ? (shreg >> 1) : (shreg << 1);

  // Ready only where a new word can start without breaking SCLK timing:
  // idle, waiting inside an open frame, or the last cycle of a non-final TRAIL.
  assign s_ready = (state == IDLE) || (state == WAIT) ||
                   ((state == TRAIL) && div_done && !last_q);
  assign xfer    = s_valid && s_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      last_q   <= 1'b0;
      spi.sclk <= 1'b0;
      spi.cs_n <= 1'b1;
      spi.mosi <= 1'b0;
    end else if (xfer) begin
      // NOTE: non-blocking assignments keep every register updating from the
      // same pre-edge values, so the outputs and state move together.
      state    <= LEAD;
      shreg    <= s_data;
      last_q   <= s_last;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      spi.cs_n <= 1'b0;
      spi.sclk <= 1'b0;
      spi.mosi <= first_bit(s_data);
    end else begin
      case (state)
        IDLE, WAIT: begin
          div_cnt <= '0;
        end

        LEAD, LOW: begin
          if (div_done) begin
            state    <= HIGH;
            div_cnt  <= '0;
            spi.sclk <= 1'b1;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HIGH: begin
          if (div_done) begin
            div_cnt  <= '0;
            spi.sclk <= 1'b0;
            if (bit_cnt == BIT_MAX) begin
              state <= TRAIL;
            end else begin
              state    <= LOW;
              bit_cnt  <= bit_cnt + BIT_W'(1);
              shreg    <= shifted;
              spi.mosi <= first_bit(shifted);
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        TRAIL: begin
          if (div_done) begin
            div_cnt <= '0;
            if (last_q) begin
              state    <= GAP;
              gap_cnt  <= '0;
              spi.cs_n <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        GAP: begin
          if (gap_cnt == GAP_MAX) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: stimulus queues expected words and frames,
// monitors on the SPI bus pop and compare them as the DUT produces them.
module tb_spi_master_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_valid;
  logic       s_ready;
  logic       busy;
  logic [7:0] l_data;
  logic       l_last;
  logic       l_valid;
  logic       l_ready;
  logic       l_busy;

  spi_bus bus ();
  spi_bus bus_l ();

  always #5 clk = ~clk;

  spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(2), .LSB_FIRST(0)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_last(s_last),
    .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .spi(bus)
  );

  spi_master_tx #(.DATA_W(8), .CLK_DIV(2), .CS_GAP(2), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .s_data(l_data), .s_last(l_last),
    .s_valid(l_valid), .s_ready(l_ready), .busy(l_busy), .spi(bus_l)
  );

  typedef struct {
    int len;
    int edges;
  } frame_t;

  frame_t     frame_q[$];
  logic [7:0] word_q[$];
  logic [7:0] lword_q[$];
  int         n_cmp  = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame monitor: cs_n low length and sclk rising edges per frame.
  initial begin
    int   f_len;
    int   f_edges;
    logic in_frame;
    logic sclk_p;
    frame_t exp_f;
    f_len = 0; f_edges = 0; in_frame = 1'b0; sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        f_len = 0; f_edges = 0; in_frame = 1'b0; sclk_p = 1'b0;
      end else begin
        if (!bus.cs_n) begin
          f_len++;
          if (bus.sclk && !sclk_p) f_edges++;
          in_frame = 1'b1;
        end else if (in_frame) begin
          if (frame_q.size() == 0) begin
            check("frame_unexpected", 32'(f_len), 32'd0);
          end else begin
            exp_f = frame_q.pop_front();
            check("frame_len", 32'(f_len), 32'(exp_f.len));
            check("frame_edges", 32'(f_edges), 32'(exp_f.edges));
          end
          f_len = 0; f_edges = 0; in_frame = 1'b0;
        end
        sclk_p = bus.sclk;
      end
    end
  end

  // Word monitor, MSB-first instance: bits sampled on sclk rising edges.
  initial begin
    int         nb;
    logic [7:0] w;
    logic       sclk_p;
    nb = 0; w = '0; sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; sclk_p = 1'b0;
      end else begin
        if (bus.sclk && !sclk_p) begin
          w = {w[6:0], bus.mosi};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (word_q.size() == 0) check("word_unexpected", 32'(w), 32'hFFFF_FFFF);
            else check("word_msb", 32'(w), 32'(word_q.pop_front()));
          end
        end
        sclk_p = bus.sclk;
      end
    end
  end

  // Word monitor, LSB-first instance.
  initial begin
    int         nb;
    logic [7:0] w;
    logic       sclk_p;
    nb = 0; w = '0; sclk_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nb = 0; sclk_p = 1'b0;
      end else begin
        if (bus_l.sclk && !sclk_p) begin
          w = {bus_l.mosi, w[7:1]};
          nb++;
          if (nb == 8) begin
            nb = 0;
            if (lword_q.size() == 0) check("lword_unexpected", 32'(w), 32'hFFFF_FFFF);
            else check("word_lsb", 32'(w), 32'(lword_q.pop_front()));
          end
        end
        sclk_p = bus_l.sclk;
      end
    end
  end

  // Drive a word at the current (negedge) time and hold until it transfers.
  task automatic present(input logic [7:0] d, input logic l);
    int k;
    s_data = d; s_last = l; s_valid = 1'b1;
    k = 0;
    while (!s_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic l);
    @(negedge clk);
    present(d, l);
  endtask

  task automatic drop();
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int   k;
    int   edges;
    logic p;

    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    l_valid = 1'b0; l_data = '0; l_last = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cs_n", 32'(bus.cs_n), 32'd1);
    check("rst_sclk", 32'(bus.sclk), 32'd0);
    check("rst_mosi", 32'(bus.mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(s_ready), 32'd1);

    // Single word 0xA5, offered in the first cycle after reset release
    word_q.push_back(8'hA5);
    frame_q.push_back('{len: 34, edges: 8});
    rst_n = 1'b1;
    present(8'hA5, 1'b1);
    check("lead_cs_n", 32'(bus.cs_n), 32'd0);
    check("lead_mosi", 32'(bus.mosi), 32'd1);
    drop();
    k = 0;
    while (bus.cs_n == 1'b0 && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("gap1_cs_n", 32'(bus.cs_n), 32'd1);
    check("gap1_ready", 32'(s_ready), 32'd0);
    check("gap1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("gap2_cs_n", 32'(bus.cs_n), 32'd1);
    check("gap2_ready", 32'(s_ready), 32'd0);
    @(negedge clk);
    check("idle_ready", 32'(s_ready), 32'd1);
    check("idle_busy", 32'(busy), 32'd0);

    // Burst: 0x3C then 0xC3 in one frame, s_valid held
    word_q.push_back(8'h3C);
    word_q.push_back(8'hC3);
    frame_q.push_back('{len: 68, edges: 16});
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b1);
    drop();
    wait_idle();

    // Stall: 0x81, ten WAIT cycles, then 0x7E
    word_q.push_back(8'h81);
    word_q.push_back(8'h7E);
    frame_q.push_back('{len: 78, edges: 16});
    send(8'h81, 1'b0);
    drop();
    k = 0;
    while (!(s_ready && !bus.cs_n) && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("trail_ready", 32'(s_ready), 32'd1);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      check("wait_cs_n", 32'(bus.cs_n), 32'd0);
      check("wait_sclk", 32'(bus.sclk), 32'd0);
      check("wait_mosi", 32'(bus.mosi), 32'd1);
      check("wait_ready", 32'(s_ready), 32'd1);
      if (i == 10) present(8'h7E, 1'b1);
    end
    drop();
    wait_idle();

    // Mid-word reset after the third rising edge, then a clean 0x5A frame
    send(8'hFF, 1'b1);
    drop();
    edges = 0; p = 1'b0; k = 0;
    while (edges < 3 && k < 100) begin
      @(negedge clk);
      if (bus.sclk && !p) edges++;
      p = bus.sclk;
      k++;
    end
    check("abort_edges", 32'(edges), 32'd3);
    rst_n = 1'b0;
    #1;
    check("abort_cs_n", 32'(bus.cs_n), 32'd1);
    check("abort_sclk", 32'(bus.sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(s_ready), 32'd1);
    repeat (3) @(negedge clk);
    word_q.push_back(8'h5A);
    frame_q.push_back('{len: 34, edges: 8});
    rst_n = 1'b1;
    present(8'h5A, 1'b1);
    drop();
    wait_idle();

    // LSB-first instance: 0x01 must arrive as 1 followed by seven 0s
    lword_q.push_back(8'h01);
    @(negedge clk);
    l_data = 8'h01; l_last = 1'b1; l_valid = 1'b1;
    k = 0;
    while (!l_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check("lsb_first_bit", 32'(bus_l.mosi), 32'd1);
    @(negedge clk);
    l_valid = 1'b0;
    k = 0;
    while (l_busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("lsb_idle", 32'(l_busy), 32'd0);

    // Drain scoreboards
    k = 0;
    while ((word_q.size() + lword_q.size() + frame_q.size()) != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("word_q_left", 32'(word_q.size()), 32'd0);
    check("lword_q_left", 32'(lword_q.size()), 32'd0);
    check("frame_q_left", 32'(frame_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
